// File: rtl/led_pattern_sequencer.sv
// Four-mode LED pattern engine with debounced slower/faster/restore keys on CLOCK_50.
// Latency: key press acts 2 sync + DEBOUNCE + 2 clocks after a stable edge; LEDs lag state by 1 clock; no backpressure.
module led_pattern_sequencer #(
    parameter int GREEN_W        = 8,
    parameter int RED_W          = 10,
    parameter int TICK_DEFAULT   = 25000000,
    parameter int TICK_STEP      = 12500000,
    parameter int TICK_MIN       = 12500000,
    parameter int TICK_MAX       = 250000000,
    parameter int FLIPS_PER_MODE = 6,
    parameter int DEBOUNCE       = 500000
) (
    input  logic               CLOCK_50,
    input  logic               RESET,
    input  logic [2:0]         KEY,
    output logic [GREEN_W-1:0] LEDG,
    output logic [RED_W-1:0]   LEDR,
    output logic [1:0]         MODE
);

    localparam int TOT_W = GREEN_W + RED_W;
    localparam int POS_W = $clog2(TOT_W);
    localparam int FL_W  = (FLIPS_PER_MODE > 1) ? $clog2(FLIPS_PER_MODE) : 1;
    localparam int DB_W  = $clog2(DEBOUNCE + 1);

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);
    localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(FLIPS_PER_MODE - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(TOT_W - 1);

    localparam logic [31:0] P_DEF  = 32'(TICK_DEFAULT);
    localparam logic [31:0] P_STEP = 32'(TICK_STEP);
    localparam logic [31:0] P_MIN  = 32'(TICK_MIN);
    localparam logic [31:0] P_MAX  = 32'(TICK_MAX);
    localparam logic [32:0] STEP33 = 33'(TICK_STEP);
    localparam logic [32:0] MIN33  = 33'(TICK_MIN);
    localparam logic [32:0] MAX33  = 33'(TICK_MAX);

    typedef enum logic [1:0] {
        M_GREEN = 2'd0,
        M_RED   = 2'd1,
        M_BOTH  = 2'd2,
        M_CHASE = 2'd3
    } mode_t;

    // ---------------- key path ----------------
    logic [2:0]      sync1;
    logic [2:0]      sync2;
    logic [2:0]      deb;
    logic [2:0]      deb_d;
    logic [2:0]      press;
    logic [DB_W-1:0] db_cnt [3];

    // db_cnt counts consecutive synchronised samples that disagree with the debounced level.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            sync1 <= '1;
            sync2 <= '1;
            deb   <= '1;
            deb_d <= '1;
            press <= '0;
            for (int k = 0; k < 3; k++) begin
                db_cnt[k] <= '0;
            end
        end else begin
            sync1 <= KEY;
            sync2 <= sync1;
            deb_d <= deb;
            press <= deb_d & ~deb;
            for (int k = 0; k < 3; k++) begin
                if (sync2[k] != deb[k]) begin
                    if (db_cnt[k] == DB_LAST) begin
                        deb[k]    <= sync2[k];
                        db_cnt[k] <= '0;
                    end else begin
                        db_cnt[k] <= db_cnt[k] + 1'b1;
                    end
                end else begin
                    db_cnt[k] <= '0;
                end
            end
        end
    end

    logic slow_pls;
    logic fast_pls;
    logic rest_pls;
    assign slow_pls = press[0];
    assign fast_pls = press[1];
    assign rest_pls = press[2];

    // ---------------- pattern core ----------------
    logic [31:0]      cnt;
    logic [31:0]      period;
    logic [FL_W-1:0]  flips;
    logic             phase;
    mode_t            mode;
    logic [POS_W-1:0] pos;

    logic             tick;
    logic [POS_W-1:0] pos_next;
    mode_t            mode_next;
    logic [32:0]      sum33;
    logic [31:0]      slow_val;
    logic [31:0]      fast_val;
    logic [TOT_W-1:0] onehot;

    always_comb begin
        tick      = (cnt == period - 32'd1);
        pos_next  = (pos == POS_LAST) ? '0 : pos + 1'b1;
        mode_next = mode_t'(mode + 2'd1);
        sum33     = {1'b0, period} + STEP33;
        slow_val  = (sum33 > MAX33) ? P_MAX : sum33[31:0];
        // Compare before subtracting so a small period can never wrap below zero.
        fast_val  = ({1'b0, period} < MIN33 + STEP33) ? P_MIN : period - P_STEP;
        onehot    = TOT_W'(1) << pos;
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            cnt    <= '0;
            period <= P_DEF;
            flips  <= '0;
            phase  <= 1'b0;
            mode   <= M_RED;
            pos    <= '0;
            LEDG   <= '0;
            LEDR   <= '0;
        end else begin
            case (mode)
                M_GREEN: begin
                    LEDG <= {GREEN_W{phase}};
                    LEDR <= '0;
                end
                M_RED: begin
                    LEDG <= '0;
                    LEDR <= {RED_W{phase}};
                end
                M_BOTH: begin
                    LEDG <= {GREEN_W{phase}};
                    LEDR <= {RED_W{phase}};
                end
                M_CHASE: begin
                    LEDG <= onehot[GREEN_W-1:0];
                    LEDR <= onehot[TOT_W-1:GREEN_W];
                end
            endcase

            if (rest_pls) begin
                period <= P_DEF;
                cnt    <= '0;
                flips  <= '0;
                phase  <= 1'b0;
                mode   <= M_RED;
                pos    <= '0;
            end else begin
                cnt <= tick ? '0 : cnt + 32'd1;
                if (tick) begin
                    phase <= ~phase;
                    if (flips == FL_LAST) begin
                        flips <= '0;
                        mode  <= mode_next;
                        pos   <= (mode_next == M_CHASE) ? '0 : pos_next;
                    end else begin
                        flips <= flips + 1'b1;
                        pos   <= pos_next;
                    end
                end
                // Opposing presses in one cycle cancel; a real period change restarts the count.
                if (slow_pls && !fast_pls && period < P_MAX) begin
                    period <= slow_val;
                    cnt    <= '0;
                end else if (fast_pls && !slow_pls && period > P_MIN) begin
                    period <= fast_val;
                    cnt    <= '0;
                end
            end
        end
    end

    assign MODE = mode;

endmodule
